// File: rtl/alu_muldiv_iter_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// The master drives operands and flow control; the unit is the slave.
interface alu_muldiv_iter_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;

   modport master (
      output flush, in_valid, op, src1, src2, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  flush, in_valid, op, src1, src2, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator, one bit per cycle.
module alu_muldiv_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input logic              clk,
   input logic              rst,
   alu_muldiv_iter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                zero_q, zero_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   logic                signed1, signed2, s1_neg, s2_neg;
   logic                div_zero, div_ovf, neg_in;
   logic [XLEN-1:0]     a_abs, b_abs;
   logic [XLEN:0]       mul_sum, rem_shift, rem_sub;
   logic                q_bit;
   logic [2*XLEN-1:0]   mul_next, div_next, step_next, prod_fix;
   logic [XLEN-1:0]     div_sel, div_fix, final_res;

   assign signed1  = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
   assign signed2  = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
   assign s1_neg   = signed1 && bus.src1[XLEN-1];
   assign s2_neg   = signed2 && bus.src2[XLEN-1];
   assign a_abs    = s1_neg ? -bus.src1 : bus.src1;
   assign b_abs    = s2_neg ? -bus.src2 : bus.src2;
   assign div_zero = bus.op[2] && (bus.src2 == '0);
   assign div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                     (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src2 == '1);

   // REM takes the dividend's sign; every other signed op takes the product/quotient sign.
   always_comb begin
      neg_in = 1'b0;
      case (bus.op)
         3'd1, 3'd2, 3'd4: neg_in = s1_neg ^ s2_neg;
         3'd6:             neg_in = s1_neg;
         default:          neg_in = 1'b0;
      endcase
   end

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
   assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
   assign rem_sub   = rem_shift - {1'b0, opb_q};
   assign q_bit     = ~rem_sub[XLEN];
   assign div_next  = {(q_bit ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
   assign step_next = op_q[2] ? div_next : mul_next;
   assign prod_fix  = neg_q ? -step_next : step_next;
   assign div_sel   = op_q[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
   assign div_fix   = neg_q ? -div_sel : div_sel;

   always_comb begin
      final_res = div_fix;
      case (op_q)
         3'd0:             final_res = step_next[XLEN-1:0];
         3'd1, 3'd2, 3'd3: final_res = prod_fix[2*XLEN-1:XLEN];
         default:          final_res = div_fix;
      endcase
   end

   // The last iteration also applies sign correction, so DONE follows XLEN CALC cycles.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      op_d        = op_q;
      neg_d       = neg_q;
      result_d    = result_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && !bus.flush) begin
               op_d       = bus.op;
               neg_d      = neg_in;
               acc_d      = {{XLEN{1'b0}}, a_abs};
               opb_d      = b_abs;
               in_ready_d = 1'b0;
               if (div_zero) begin
                  result_d    = bus.op[1] ? bus.src1 : '1;
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else if (div_ovf) begin
                  result_d    = bus.op[1] ? '0 : bus.src1;
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  cnt_d   = CNT_W'(XLEN);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d    = final_res;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
      if (bus.flush) begin
         state_d     = IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed self-checking bench for alu_muldiv_iter at XLEN=32 with
// hand-computed expected results, latencies, back-pressure, flush and reset.
module tb_alu_muldiv_iter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_muldiv_iter_if #(.XLEN(32)) bus ();

   alu_muldiv_iter #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents one op, waits for out_valid (bounded); lat = 1 means visible right after the accept edge.
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat);
      @(negedge clk);
      bus.op       = o;
      bus.src1     = a;
      bus.src2     = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic releaseResult();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic expz,
                        input int explat);
      int lat;
      applyStimulus(o, a, b, lat);
      checkOutput({tag, " lat"}, 64'(lat), 64'(explat));
      checkOutput({tag, " res"}, 64'(bus.result), 64'(exp));
      checkOutput({tag, " zero"}, 64'(bus.zero), 64'(expz));
      releaseResult();
      checkOutput({tag, " ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int seen;
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 3'd0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.out_ready = 1'b0;

      @(negedge clk);
      checkOutput("rst in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst result", 64'(bus.result), 64'd0);
      checkOutput("rst zero", 64'(bus.zero), 64'd1);
      rst = 1'b0;

      runOp("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
      runOp("mulh", 3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
      runOp("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
      runOp("mulhu small", 3'd3, 32'd5, 32'd6, 32'h0, 1'b1, 33);

      runOp("div", 3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 1'b0, 33);
      runOp("rem", 3'd6, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 1'b0, 33);
      runOp("divu", 3'd5, 32'd20, 32'd6, 32'd3, 1'b0, 33);
      runOp("remu", 3'd7, 32'd20, 32'd6, 32'd2, 1'b0, 33);

      runOp("div0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
      runOp("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1'b0, 1);
      runOp("divu0", 3'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
      runOp("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
      runOp("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);

      $display("[TB] back-pressure");
      applyStimulus(3'd5, 32'd100, 32'd7, lat);
      checkOutput("bp lat", 64'(lat), 64'd33);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.op       = 3'd0;
         bus.src1     = 32'd9;
         bus.src2     = 32'd9;
         @(negedge clk);
         checkOutput("bp result", 64'(bus.result), 64'd14);
         checkOutput("bp in_ready", 64'(bus.in_ready), 64'd0);
         checkOutput("bp valid", 64'(bus.out_valid), 64'd1);
      end
      bus.in_valid = 1'b0;
      releaseResult();
      checkOutput("bp idle ready", 64'(bus.in_ready), 64'd1);
      checkOutput("bp idle valid", 64'(bus.out_valid), 64'd0);
      runOp("after bp", 3'd0, 32'd5, 32'd6, 32'd30, 1'b0, 33);

      $display("[TB] flush");
      @(negedge clk);
      bus.op       = 3'd4;
      bus.src1     = 32'd1000;
      bus.src2     = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 11; i++) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush ready", 64'(bus.in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      checkOutput("flush no valid", 64'(seen), 64'd0);
      runOp("mul after flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 33);

      applyStimulus(3'd4, 32'd5, 32'd0, lat);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      checkOutput("flush done valid", 64'(bus.out_valid), 64'd0);
      checkOutput("flush done ready", 64'(bus.in_ready), 64'd1);

      bus.op       = 3'd4;
      bus.src1     = 32'd5;
      bus.src2     = 32'd0;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      checkOutput("flush idle ready", 64'(bus.in_ready), 64'd1);
      checkOutput("flush idle valid", 64'(bus.out_valid), 64'd0);

      $display("[TB] async reset");
      bus.op       = 3'd0;
      bus.src1     = 32'd11;
      bus.src2     = 32'd13;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("arst out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("arst result", 64'(bus.result), 64'd0);
      checkOutput("arst zero", 64'(bus.zero), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      checkOutput("arst no valid", 64'(seen), 64'd0);
      runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_iter.md
Name: alu_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension ops. It is the sequential companion to the single-cycle integer ALU.
- Sits in EX beside the ALU. The pipeline stalls on `in_ready`/`out_valid` while an operation is in flight.
- Uses a radix-2 shift-add multiplier and a restoring divider. One datapath is shared; one bit is processed per cycle.

Parameters:
- `XLEN`, 32: operand/result width; any even value ≥ 8.
- `CNT_W`, `$clog2(XLEN)+1`: iteration counter width; derived, do not override.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of the in-flight operation (branch mispredict/trap).
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  unit can accept an operation.
- `op`  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1`  in  XLEN  rs1 operand.
- `src2`  in  XLEN  rs2 operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  XLEN  result.
- `zero`  out  1  `result == 0` (qualified by `out_valid`).

Behaviour:
- Reset (async, any state):
  - state = IDLE; `in_ready` = 1; `out_valid` = 0; `result` = 0; `zero` = 1.
  - Internal accumulators and counter cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && !flush`, latch `op`/`src1`/`src2` into registers.
  - Zero-cycle special cases go straight to DONE with the result registered:
    - divide by zero (`op` 4–7, `src2 == 0`): DIV/DIVU result = all ones; REM/REMU result = `src1`.
    - signed overflow (`op` 4/6, `src1 == 1<<(XLEN-1)`, `src2` = all ones): DIV result = `src1`; REM result = 0.
  - Otherwise go to CALC with counter = XLEN.
- Operand preparation at accept:
  - Signed ops take the absolute value of each operand treated as signed:
    - MULH: both operands.
    - MULHSU: `src1` only.
    - DIV/REM: both operands.
  - Record the result sign:
    - MUL*: XOR of the operand signs.
    - DIV: XOR of the operand signs.
    - REM: sign of `src1`.
- CALC:
  - One iteration per cycle; counter decrements.
  - Multiply: 2·XLEN-bit product register.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - When counter reaches 0: apply the sign correction (two's complement of the 2·XLEN product or of the XLEN result), select the output, go to DONE.
  - Output selection:
    - MUL: product[XLEN-1:0].
    - MULH/MULHSU/MULHU: product[2XLEN-1:XLEN].
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
- DONE:
  - `out_valid` = 1; `result`/`zero` held stable until accepted.
  - On `out_ready`, return to IDLE. `in_ready` rises the following cycle; there is no same-cycle re-accept.
- Latency: accept at cycle N.
  - Normal ops: `out_valid` at N+XLEN+1.
  - Special cases: `out_valid` at N+1.
- `in_ready` = 0 in CALC and DONE; `in_valid` is ignored there.
- `flush`:
  - In any state: next state IDLE, `out_valid` = 0.
  - A result presented in the same cycle as `flush` is discarded even if `out_ready` = 1.
  - `flush` in IDLE blocks the accept that cycle.
- `rst` asserted mid-CALC aborts immediately; no partial result appears.
- All arithmetic is modulo 2^XLEN; MULHSU treats `src2` as unsigned.

Test Plan (XLEN=32):
1. MUL 7 × −3 (0xFFFFFFFD): `result` 0xFFFFFFEB. MULH of same → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Each `out_valid` exactly 33 cycles after accept.
2. DIV −20 / 6 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFE (−2); DIVU 20/6 → 3; REMU → 2; `zero` = 0.
3. DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIVU 0/0 → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0 with `zero` = 1. All have `out_valid` 1 cycle after accept.
4. Back-pressure: hold `out_ready` = 0 for 10 cycles in DONE. `result` stays stable, `in_ready` stays 0, `in_valid` pulses are ignored. Release → IDLE, next op accepted one cycle later.
5. Assert `flush` at iteration 12 of a DIV. The unit is in IDLE next cycle with `in_ready` = 1 and no `out_valid` ever appears. A following MUL 3×4 → 12.
6. Assert `rst` asynchronously mid-CALC (between clock edges). Outputs go to reset values immediately. After deassert, MULHSU 0xFFFFFFFF (−1) × 2 → 0xFFFFFFFF.
